// File: rtl/bk_sector_seq.sv
// Backup-image sector sequencer: turns load/save menu edges into a burst of
// consecutive sector transfers between the host SD interface and nvram.
//
// state  | meaning
// S_IDLE | waiting for an accepted load/save edge; sd_lba holds last value
// S_REQ  | sd_rd/sd_wr raised, waiting for sd_ack rise or ack timeout
// S_XFER | host transfer in progress, waiting for sd_ack fall
// S_DONE | last sector finished, emit bk_done pulse
// S_ERR  | ack timeout, raise sticky bk_error
module bk_sector_seq #(
    parameter int unsigned SECTORS_LOG2 = 6,
    parameter int unsigned SLOT_BITS    = 2,
    parameter logic [23:0] ACK_TIMEOUT  = 24'd5000000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 img_mounted,
    input  logic                 img_readonly,
    input  logic [63:0]          img_size,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic [SLOT_BITS-1:0] slot,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    output logic                 bk_ena,
    output logic                 bk_loading,
    output logic                 bk_busy,
    output logic                 bk_done,
    output logic                 bk_error
);

    localparam int unsigned LBA_BITS = SLOT_BITS + SECTORS_LOG2;
    localparam logic [SECTORS_LOG2-1:0] IDX_ONE = SECTORS_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state;
    logic [SECTORS_LOG2-1:0] idx;
    logic [SLOT_BITS-1:0]    slot_lat;
    logic                    dir_load;
    logic [23:0]             to_cnt;

    logic dl_prev;
    logic load_prev;
    logic save_prev;
    logic ack_q;
    logic ack_prev;

    logic                    dl_rise;
    logic                    arm_set;
    logic                    load_lvl;
    logic                    save_lvl;
    logic                    load_edge;
    logic                    save_edge;
    logic                    ack_rise;
    logic                    ack_fall;
    logic                    idx_last;
    logic [SECTORS_LOG2-1:0] idx_inc;
    logic [23:0]             cnt_inc;
    logic                    to_hit;

    function automatic logic [31:0] make_lba(input logic [SLOT_BITS-1:0] s,
                                              input logic [SECTORS_LOG2-1:0] i);
        logic [31:0] v;
        v = '0;
        v[LBA_BITS-1:0] = {s, i};
        return v;
    endfunction

    always_comb begin
        dl_rise   = ioctl_download & ~dl_prev;
        arm_set   = ioctl_download & img_mounted & (img_size != 64'd0) & ~img_readonly;
        load_lvl  = load_req & bk_ena;
        save_lvl  = save_req & bk_ena;
        load_edge = load_lvl & ~load_prev;
        save_edge = save_lvl & ~save_prev;
        // sd_ack goes through one capture stage, so edges are seen a cycle late
        ack_rise  = ack_q & ~ack_prev;
        ack_fall  = ~ack_q & ack_prev;
        idx_last  = &idx;
        idx_inc   = idx + IDX_ONE;
        cnt_inc   = to_cnt + 24'd1;
        to_hit    = (ACK_TIMEOUT != 24'd0) && (cnt_inc == ACK_TIMEOUT);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            slot_lat   <= '0;
            dir_load   <= 1'b0;
            to_cnt     <= '0;
            dl_prev    <= 1'b0;
            load_prev  <= 1'b0;
            save_prev  <= 1'b0;
            ack_q      <= 1'b0;
            ack_prev   <= 1'b0;
            sd_lba     <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            bk_ena     <= 1'b0;
            bk_loading <= 1'b0;
            bk_busy    <= 1'b0;
            bk_done    <= 1'b0;
            bk_error   <= 1'b0;
        end else begin
            dl_prev   <= ioctl_download;
            load_prev <= load_lvl;
            save_prev <= save_lvl;
            ack_q     <= sd_ack;
            ack_prev  <= ack_q;
            bk_done   <= 1'b0;

            if (arm_set) begin
                bk_ena <= 1'b1;
            end else if (dl_rise) begin
                bk_ena <= 1'b0;
            end

            // A new ROM download invalidates whatever transfer is in flight
            if (dl_rise && state != S_IDLE) begin
                state      <= S_IDLE;
                sd_rd      <= 1'b0;
                sd_wr      <= 1'b0;
                bk_loading <= 1'b0;
                bk_busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load_edge || save_edge) begin
                            state      <= S_REQ;
                            idx        <= '0;
                            slot_lat   <= slot;
                            dir_load   <= load_edge;
                            to_cnt     <= '0;
                            sd_lba     <= make_lba(slot, '0);
                            sd_rd      <= load_edge;
                            sd_wr      <= ~load_edge;
                            bk_loading <= load_edge;
                            bk_busy    <= 1'b1;
                            bk_error   <= 1'b0;
                        end
                    end
                    S_REQ: begin
                        to_cnt <= cnt_inc;
                        if (ack_rise) begin
                            state <= S_XFER;
                            sd_rd <= 1'b0;
                            sd_wr <= 1'b0;
                        end else if (to_hit) begin
                            state <= S_ERR;
                            sd_rd <= 1'b0;
                            sd_wr <= 1'b0;
                        end
                    end
                    S_XFER: begin
                        if (ack_fall) begin
                            if (idx_last) begin
                                state <= S_DONE;
                            end else begin
                                state  <= S_REQ;
                                idx    <= idx_inc;
                                sd_lba <= make_lba(slot_lat, idx_inc);
                                sd_rd  <= dir_load;
                                sd_wr  <= ~dir_load;
                                to_cnt <= '0;
                            end
                        end
                    end
                    S_DONE: begin
                        state      <= S_IDLE;
                        bk_done    <= 1'b1;
                        bk_loading <= 1'b0;
                        bk_busy    <= 1'b0;
                    end
                    S_ERR: begin
                        state      <= S_IDLE;
                        sd_rd      <= 1'b0;
                        sd_wr      <= 1'b0;
                        bk_error   <= 1'b1;
                        bk_loading <= 1'b0;
                        bk_busy    <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bk_sector_seq.sv
// Scoreboard bench for bk_sector_seq: stimulus queues expected request/done/error
// events, a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_bk_sector_seq;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        img_mounted;
    logic        img_readonly;
    logic [63:0] img_size;
    logic        load_req;
    logic        save_req;
    logic [1:0]  slot;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic        bk_ena;
    logic        bk_loading;
    logic        bk_busy;
    logic        bk_done;
    logic        bk_error;

    always #5 clk_sys = ~clk_sys;

    bk_sector_seq #(
        .SECTORS_LOG2(6),
        .SLOT_BITS   (2),
        .ACK_TIMEOUT (24'd100)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .img_mounted   (img_mounted),
        .img_readonly  (img_readonly),
        .img_size      (img_size),
        .load_req      (load_req),
        .save_req      (save_req),
        .slot          (slot),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .bk_ena        (bk_ena),
        .bk_loading    (bk_loading),
        .bk_busy       (bk_busy),
        .bk_done       (bk_done),
        .bk_error      (bk_error)
    );

    localparam logic [1:0] EV_REQ  = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        rd;
        logic        wr;
        logic [31:0] lba;
    } ev_t;

    ev_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   req_seen = 0;
    logic exp_loading = 1'b0;
    logic host_en = 1'b1;
    logic prev_req = 1'b0;
    logic prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic rd, input logic wr,
                           input logic [31:0] lba);
        ev_t e;
        e.kind = kind;
        e.rd   = rd;
        e.wr   = wr;
        e.lba  = lba;
        exp_q.push_back(e);
    endtask

    task automatic push_burst(input logic rd, input logic [31:0] base, input int n, input logic done);
        for (int i = 0; i < n; i++) push_ev(EV_REQ, rd, ~rd, base + 32'(i));
        if (done) push_ev(EV_DONE, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic pop_cmp(input ev_t got);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d rd=%0b wr=%0b lba=0x%0h, expected none",
                     got.kind, got.rd, got.wr, got.lba);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                errors++;
                $display("FAIL event: got kind=%0d rd=%0b wr=%0b lba=0x%0h expected kind=%0d rd=%0b wr=%0b lba=0x%0h",
                         got.kind, got.rd, got.wr, got.lba, e.kind, e.rd, e.wr, e.lba);
            end
        end
    endtask

    always @(negedge clk_sys) begin
        ev_t got;
        if ((sd_rd || sd_wr) && !prev_req) begin
            got.kind = EV_REQ;
            got.rd   = sd_rd;
            got.wr   = sd_wr;
            got.lba  = sd_lba;
            req_seen++;
            pop_cmp(got);
        end
        if (bk_done) begin
            got = '0;
            got.kind = EV_DONE;
            pop_cmp(got);
        end
        if (bk_error && !prev_err) begin
            got = '0;
            got.kind = EV_ERR;
            pop_cmp(got);
        end
        check("rd_wr_exclusive", 32'(sd_rd & sd_wr), 32'd0);
        if (bk_busy) check("loading_level", 32'(bk_loading), 32'(exp_loading));
        prev_req = sd_rd | sd_wr;
        prev_err = bk_error;
    end

    // Host: acknowledge each request 3 cycles after seeing it, hold ack for 20 cycles
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (host_en && (sd_rd || sd_wr) && !sd_ack) begin
                repeat (3) @(negedge clk_sys);
                sd_ack = 1'b1;
                repeat (20) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    task automatic check_idle(input string name, input logic ena);
        check({name, "_rd"},      32'(sd_rd),      32'd0);
        check({name, "_wr"},      32'(sd_wr),      32'd0);
        check({name, "_loading"}, 32'(bk_loading), 32'd0);
        check({name, "_busy"},    32'(bk_busy),    32'd0);
        check({name, "_done"},    32'(bk_done),    32'd0);
        check({name, "_error"},   32'(bk_error),   32'd0);
        check({name, "_ena"},     32'(bk_ena),     32'(ena));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bk_busy) && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_end"}, 32'(bk_busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_reqs(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (req_seen < target && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_reqs_seen"}, 32'(req_seen), 32'(target));
    endtask

    task automatic mount_valid();
        img_size     = 64'd32768;
        img_readonly = 1'b0;
        img_mounted  = 1'b1;
        tick(1);
        img_mounted  = 1'b0;
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        ioctl_download = 1'b0;
        img_mounted = 1'b0;
        img_readonly = 1'b0;
        img_size = 64'd0;
        load_req = 1'b0;
        save_req = 1'b0;
        slot = 2'd0;
        tick(3);
        check_idle("reset", 1'b0);
        check("reset_lba", sd_lba, 32'd0);
        reset = 1'b0;
        tick(2);

        // Arming rules
        ioctl_download = 1'b1;
        tick(1);
        check("ena_before_mount", 32'(bk_ena), 32'd0);
        mount_valid();
        check("arm_set", 32'(bk_ena), 32'd1);
        ioctl_download = 1'b0;
        tick(1);
        ioctl_download = 1'b1;
        tick(1);
        check("dl_rise_clear", 32'(bk_ena), 32'd0);
        img_readonly = 1'b1;
        img_size = 64'd32768;
        img_mounted = 1'b1;
        tick(1);
        img_mounted = 1'b0;
        img_readonly = 1'b0;
        check("ro_mount", 32'(bk_ena), 32'd0);
        img_size = 64'd0;
        img_mounted = 1'b1;
        tick(1);
        img_mounted = 1'b0;
        check("size0_mount", 32'(bk_ena), 32'd0);
        ioctl_download = 1'b0;
        tick(1);
        ioctl_download = 1'b1;
        img_size = 64'd32768;
        img_mounted = 1'b1;
        tick(1);
        img_mounted = 1'b0;
        check("set_wins", 32'(bk_ena), 32'd1);
        ioctl_download = 1'b0;
        tick(2);

        // Load slot 2: 64 reads at 0x80..0xBF
        slot = 2'd2;
        exp_loading = 1'b1;
        push_burst(1'b1, 32'h80, 64, 1'b1);
        load_req = 1'b1;
        tick(1);
        check("req_latency", 32'(sd_rd), 32'd1);
        check("loading_set", 32'(bk_loading), 32'd1);
        wait_drain("load_slot2", 4000);
        check("load_lba_hold", sd_lba, 32'hBF);
        load_req = 1'b0;
        tick(2);

        // Save while disarmed produces nothing
        ioctl_download = 1'b1;
        tick(1);
        check("disarm", 32'(bk_ena), 32'd0);
        save_req = 1'b1;
        tick(30);
        check("save_disarmed_busy", 32'(bk_busy), 32'd0);
        save_req = 1'b0;
        tick(1);
        mount_valid();
        ioctl_download = 1'b0;
        tick(1);
        check("rearm", 32'(bk_ena), 32'd1);

        slot = 2'd0;
        exp_loading = 1'b0;
        push_burst(1'b0, 32'h00, 64, 1'b1);
        save_req = 1'b1;
        tick(1);
        check("save_wr", 32'(sd_wr), 32'd1);
        wait_drain("save_slot0", 4000);
        save_req = 1'b0;
        tick(2);

        // Simultaneous edges: load wins; later edge while busy ignored
        slot = 2'd3;
        exp_loading = 1'b1;
        push_burst(1'b1, 32'hC0, 64, 1'b1);
        load_req = 1'b1;
        save_req = 1'b1;
        tick(1);
        slot = 2'd1;
        tick(40);
        load_req = 1'b0;
        save_req = 1'b0;
        tick(2);
        save_req = 1'b1;
        wait_drain("simul_slot3", 4000);
        tick(60);
        save_req = 1'b0;
        tick(2);

        // Ack timeout
        host_en = 1'b0;
        slot = 2'd1;
        exp_loading = 1'b1;
        push_ev(EV_REQ, 1'b1, 1'b0, 32'h40);
        push_ev(EV_ERR, 1'b0, 1'b0, 32'd0);
        load_req = 1'b1;
        tick(1);
        hi = 0;
        while (sd_rd && hi < 300) begin
            hi++;
            tick(1);
        end
        check("timeout_cycles", 32'(hi), 32'd100);
        tick(1);
        check("timeout_error", 32'(bk_error), 32'd1);
        check("timeout_loading", 32'(bk_loading), 32'd0);
        check("timeout_busy", 32'(bk_busy), 32'd0);
        tick(5);
        check("timeout_pending", 32'(exp_q.size()), 32'd0);
        load_req = 1'b0;
        host_en = 1'b1;
        tick(2);
        exp_loading = 1'b0;
        push_burst(1'b0, 32'h40, 64, 1'b1);
        save_req = 1'b1;
        tick(1);
        check("error_cleared", 32'(bk_error), 32'd0);
        wait_drain("save_slot1", 4000);
        save_req = 1'b0;
        tick(2);

        // Abort by download rise after 10 sectors
        slot = 2'd0;
        exp_loading = 1'b1;
        req_seen = 0;
        push_burst(1'b1, 32'h00, 11, 1'b0);
        load_req = 1'b1;
        wait_reqs("abort", 11, 2000);
        ioctl_download = 1'b1;
        tick(1);
        check_idle("abort", 1'b0);
        load_req = 1'b0;
        tick(40);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Reset at sector 5
        mount_valid();
        ioctl_download = 1'b0;
        tick(1);
        slot = 2'd2;
        req_seen = 0;
        push_burst(1'b1, 32'h80, 6, 1'b0);
        load_req = 1'b1;
        wait_reqs("midreset", 6, 1000);
        reset = 1'b1;
        tick(1);
        check_idle("midreset", 1'b0);
        check("midreset_lba", sd_lba, 32'd0);
        reset = 1'b0;
        load_req = 1'b0;
        tick(40);
        check("midreset_pending", 32'(exp_q.size()), 32'd0);
        check("midreset_quiet_busy", 32'(bk_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
